// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared widths, sweep FSM states and tdata packing for the DDS sweep controller
package dds_pkg;

   localparam int DDS_PHASE_W = 28;
   localparam int DDS_TDATA_W = 32;
   localparam int DDS_DWELL_W = 24;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND  = 2'd1,
      ST_DWELL = 2'd2,
      ST_DONE  = 2'd3
   } sweep_state_t;

   // The DDS config word carries the phase increment in its low bits, upper bits zero.
   function automatic logic [DDS_TDATA_W-1:0] make_tdata(input logic [DDS_PHASE_W-1:0] inc);
      make_tdata = {{(DDS_TDATA_W - DDS_PHASE_W){1'b0}}, inc};
   endfunction

endpackage

// File: rtl/dds_dwell_timer.sv
// rtl/dds_dwell_timer.sv - down-counter timing how long each sweep point is held
module dds_dwell_timer #(
   parameter int DWELL_W = 24
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [DWELL_W-1:0] load_val,
   input  logic               en,
   output logic               expire
);

   logic [DWELL_W-1:0] cnt_q;
   logic [DWELL_W-1:0] cnt_d;

   // Load a fresh dwell (zero means one clock) or count down while enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = (load_val == '0) ? DWELL_W'(1) : load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - DWELL_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Expiry on the last counted clock; a stray zero count also expires so the FSM never stalls.
   assign expire = en && (cnt_q <= DWELL_W'(1));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - phase-increment sweep sequencer feeding the DDS config stream
module dds_sweep_ctrl
   import dds_pkg::*;
#(
   parameter int PHASE_W = DDS_PHASE_W,
   parameter int TDATA_W = DDS_TDATA_W,
   parameter int DWELL_W = DDS_DWELL_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [PHASE_W-1:0] cfg_start_inc,
   input  logic [PHASE_W-1:0] cfg_stop_inc,
   input  logic [PHASE_W-1:0] cfg_step_inc,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic               cfg_continuous,
   output logic               m_axis_config_tvalid,
   input  logic               m_axis_config_tready,
   output logic [TDATA_W-1:0] m_axis_config_tdata,
   output logic [PHASE_W-1:0] cur_inc,
   output logic               busy,
   output logic               done
);

   sweep_state_t state_q, state_d;

   logic [PHASE_W-1:0] point_q, point_d;
   logic [PHASE_W-1:0] start_inc_q, start_inc_d;
   logic [PHASE_W-1:0] stop_inc_q, stop_inc_d;
   logic [PHASE_W-1:0] step_inc_q, step_inc_d;
   logic [PHASE_W-1:0] cur_inc_q, cur_inc_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic               cont_q, cont_d;
   logic               degen_q, degen_d;
   logic               abort_pend_q, abort_pend_d;
   logic               done_q, done_d;

   logic               hs;
   logic               start_ok;
   logic               send_stop;
   logic               next_ok;
   logic               wrap_ok;
   logic               timer_expire;
   logic [PHASE_W:0]   next_sum;

   assign hs        = (state_q == ST_SEND) && m_axis_config_tready;
   assign start_ok  = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start && !abort;
   assign send_stop = abort || abort_pend_q;
   // One extra bit catches a carry out of the accumulator width, which ends the sweep.
   assign next_sum  = {1'b0, point_q} + {1'b0, step_inc_q};
   assign next_ok   = !next_sum[PHASE_W] && (next_sum[PHASE_W-1:0] <= stop_inc_q) && !degen_q;
   assign wrap_ok   = cont_q && !degen_q;

   dds_dwell_timer #(
      .DWELL_W (DWELL_W)
   ) u_dwell_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (hs && !send_stop),
      .load_val (dwell_q),
      .en       (state_q == ST_DWELL),
      .expire   (timer_expire)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: a word in SEND is never retracted, so abort there waits for the handshake.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_ok) state_d = ST_SEND;
         end
         ST_SEND: begin
            if (hs) state_d = send_stop ? ST_IDLE : ST_DWELL;
         end
         ST_DWELL: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (timer_expire) begin
               state_d = (next_ok || wrap_ok) ? ST_SEND : ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from the current state.
   always_comb begin
      m_axis_config_tvalid = 1'b0;
      busy                 = 1'b0;
      case (state_q)
         ST_SEND: begin
            m_axis_config_tvalid = 1'b1;
            busy                 = 1'b1;
         end
         ST_DWELL: busy = 1'b1;
         default: ;
      endcase
   end

   // Datapath: shadow config at start, advance/wrap the point after dwell, track the loaded word.
   always_comb begin
      point_d      = point_q;
      start_inc_d  = start_inc_q;
      stop_inc_d   = stop_inc_q;
      step_inc_d   = step_inc_q;
      dwell_d      = dwell_q;
      cont_d       = cont_q;
      degen_d      = degen_q;
      cur_inc_d    = cur_inc_q;
      abort_pend_d = abort_pend_q;
      done_d       = 1'b0;
      if (start_ok) begin
         start_inc_d = cfg_start_inc;
         stop_inc_d  = cfg_stop_inc;
         step_inc_d  = cfg_step_inc;
         dwell_d     = cfg_dwell;
         cont_d      = cfg_continuous;
         degen_d     = (cfg_step_inc == '0) || (cfg_start_inc > cfg_stop_inc);
         point_d     = cfg_start_inc;
      end
      if (state_q == ST_SEND) begin
         if (hs) begin
            cur_inc_d    = point_q;
            abort_pend_d = 1'b0;
         end else if (abort) begin
            abort_pend_d = 1'b1;
         end
      end
      if ((state_q == ST_DWELL) && !abort && timer_expire) begin
         if (next_ok) begin
            point_d = next_sum[PHASE_W-1:0];
         end else if (wrap_ok) begin
            point_d = start_inc_q;
         end else begin
            done_d = 1'b1;
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         point_q      <= '0;
         start_inc_q  <= '0;
         stop_inc_q   <= '0;
         step_inc_q   <= '0;
         dwell_q      <= '0;
         cont_q       <= 1'b0;
         degen_q      <= 1'b0;
         cur_inc_q    <= '0;
         abort_pend_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         point_q      <= point_d;
         start_inc_q  <= start_inc_d;
         stop_inc_q   <= stop_inc_d;
         step_inc_q   <= step_inc_d;
         dwell_q      <= dwell_d;
         cont_q       <= cont_d;
         degen_q      <= degen_d;
         cur_inc_q    <= cur_inc_d;
         abort_pend_q <= abort_pend_d;
         done_q       <= done_d;
      end
   end

   assign m_axis_config_tdata = TDATA_W'(make_tdata(DDS_PHASE_W'(point_q)));
   assign cur_inc             = cur_inc_q;
   assign done                = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb/tb_dds_sweep_ctrl.sv - directed self-checking bench for dds_sweep_ctrl
module tb_dds_sweep_ctrl;

   localparam int PW = 28;
   localparam int TW = 32;
   localparam int DW = 24;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [PW-1:0] cfg_start_inc = '0;
   logic [PW-1:0] cfg_stop_inc = '0;
   logic [PW-1:0] cfg_step_inc = '0;
   logic [DW-1:0] cfg_dwell = '0;
   logic          cfg_continuous = 1'b0;
   logic          tready = 1'b0;
   logic          tvalid;
   logic [TW-1:0] tdata;
   logic [PW-1:0] cur_inc;
   logic          busy;
   logic          done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   logic [TW-1:0] hs_data[$];
   int hs_cyc[$];
   int done_cyc[$];

   dds_sweep_ctrl dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .start                (start),
      .abort                (abort),
      .cfg_start_inc        (cfg_start_inc),
      .cfg_stop_inc         (cfg_stop_inc),
      .cfg_step_inc         (cfg_step_inc),
      .cfg_dwell            (cfg_dwell),
      .cfg_continuous       (cfg_continuous),
      .m_axis_config_tvalid (tvalid),
      .m_axis_config_tready (tready),
      .m_axis_config_tdata  (tdata),
      .cur_inc              (cur_inc),
      .busy                 (busy),
      .done                 (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Log accepted words and done pulses mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (tvalid && tready) begin
            hs_data.push_back(tdata);
            hs_cyc.push_back(cyc);
         end
         if (done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      hs_data.delete();
      hs_cyc.delete();
      done_cyc.delete();
   endtask

   task automatic set_cfg(input int s, input int e, input int st, input int dw, input bit c);
      cfg_start_inc  = PW'(s);
      cfg_stop_inc   = PW'(e);
      cfg_step_inc   = PW'(st);
      cfg_dwell      = DW'(dw);
      cfg_continuous = c;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++; if (tvalid !== 1'b0) $display("FAIL reset_tvalid: got %0b expected 0", tvalid);
      if (tvalid !== 1'b0) errors++;
      checks++; if (tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %0d expected 0", tdata); end
      checks++; if (cur_inc !== '0) begin errors++; $display("FAIL reset_cur_inc: got %0d expected 0", cur_inc); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
      rst_n = 1'b1;
      tick();
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %0b expected 0", busy); end
   endtask

   task automatic test_basic_sweep();
      int exp_v[5] = '{1000, 1100, 1200, 1300, 1400};
      int d0, sc, got;
      clear_log();
      set_cfg(1000, 1400, 100, 4, 1'b0);
      tready = 1'b1;
      d0 = done_cnt;
      sc = cyc;
      pulse_start();
      for (int i = 0; i < 200 && done_cnt == d0; i++) tick();
      tick(); tick(); tick();
      checks++; if (hs_data.size() != 5) begin errors++; $display("FAIL basic_count: got %0d expected 5", hs_data.size()); end
      for (int i = 0; i < 5; i++) begin
         got = (i < hs_data.size()) ? int'(hs_data[i]) : -1;
         checks++; if (got != exp_v[i]) begin errors++; $display("FAIL basic_word%0d: got %0d expected %0d", i, got, exp_v[i]); end
      end
      got = (hs_cyc.size() > 0) ? hs_cyc[0] - sc : -1;
      checks++; if (got != 1) begin errors++; $display("FAIL basic_first_latency: got %0d expected 1", got); end
      for (int i = 1; i < 5; i++) begin
         got = (i < hs_cyc.size()) ? hs_cyc[i] - hs_cyc[i-1] : -1;
         checks++; if (got != 5) begin errors++; $display("FAIL basic_spacing%0d: got %0d expected 5", i, got); end
      end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt - d0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %0b expected 0", busy); end
      checks++; if (cur_inc !== PW'(1400)) begin errors++; $display("FAIL basic_cur_inc: got %0d expected 1400", cur_inc); end
   endtask

   task automatic test_stall();
      int exp_v[5] = '{1000, 1100, 1200, 1300, 1400};
      int d0, got;
      clear_log();
      set_cfg(1000, 1400, 100, 4, 1'b0);
      tready = 1'b1;
      d0 = done_cnt;
      pulse_start();
      for (int i = 0; i < 50 && hs_data.size() < 1; i++) tick();
      tready = 1'b0;
      for (int i = 0; i < 50 && tvalid !== 1'b1; i++) tick();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (tvalid !== 1'b1 || tdata !== TW'(1100) || hs_data.size() != 1) begin
            errors++;
            $display("FAIL stall_hold%0d: got tvalid=%0b tdata=%0d words=%0d expected tvalid=1 tdata=1100 words=1", i, tvalid, tdata, hs_data.size());
         end
         tick();
      end
      tready = 1'b1;
      for (int i = 0; i < 200 && done_cnt == d0; i++) tick();
      checks++; if (hs_data.size() != 5) begin errors++; $display("FAIL stall_count: got %0d expected 5", hs_data.size()); end
      for (int i = 0; i < 5; i++) begin
         got = (i < hs_data.size()) ? int'(hs_data[i]) : -1;
         checks++; if (got != exp_v[i]) begin errors++; $display("FAIL stall_word%0d: got %0d expected %0d", i, got, exp_v[i]); end
      end
      got = (hs_cyc.size() > 1) ? hs_cyc[1] - hs_cyc[0] : -1;
      checks++; if (got != 8) begin errors++; $display("FAIL stall_gap01: got %0d expected 8", got); end
      got = (hs_cyc.size() > 2) ? hs_cyc[2] - hs_cyc[1] : -1;
      checks++; if (got != 5) begin errors++; $display("FAIL stall_gap12: got %0d expected 5", got); end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL stall_done_count: got %0d expected 1", done_cnt - d0); end
   endtask

   task automatic test_continuous();
      int exp_v[6] = '{1000, 1100, 1200, 1000, 1100, 1200};
      int d0, got;
      clear_log();
      set_cfg(1000, 1250, 100, 4, 1'b1);
      tready = 1'b1;
      d0 = done_cnt;
      pulse_start();
      cfg_stop_inc = PW'(5000);
      for (int i = 0; i < 100 && hs_data.size() < 6; i++) tick();
      for (int i = 0; i < 6; i++) begin
         got = (i < hs_data.size()) ? int'(hs_data[i]) : -1;
         checks++; if (got != exp_v[i]) begin errors++; $display("FAIL cont_word%0d: got %0d expected %0d", i, got, exp_v[i]); end
      end
      for (int i = 1; i < 6; i++) begin
         got = (i < hs_cyc.size()) ? hs_cyc[i] - hs_cyc[i-1] : -1;
         checks++; if (got != 5) begin errors++; $display("FAIL cont_spacing%0d: got %0d expected 5", i, got); end
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_abort_busy: got %0b expected 0", busy); end
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL cont_abort_tvalid: got %0b expected 0", tvalid); end
      for (int i = 0; i < 20; i++) tick();
      checks++; if (hs_data.size() != 6) begin errors++; $display("FAIL cont_after_abort_words: got %0d expected 6", hs_data.size()); end
      checks++; if (done_cnt != d0) begin errors++; $display("FAIL cont_no_done: got %0d expected %0d", done_cnt, d0); end
   endtask

   task automatic test_overflow();
      int d0, got;
      clear_log();
      set_cfg(268435440, 268435455, 10, 2, 1'b0);
      tready = 1'b1;
      d0 = done_cnt;
      pulse_start();
      for (int i = 0; i < 100 && done_cnt == d0; i++) tick();
      tick(); tick();
      checks++; if (hs_data.size() != 2) begin errors++; $display("FAIL ovf_count: got %0d expected 2", hs_data.size()); end
      got = (hs_data.size() > 0) ? int'(hs_data[0]) : -1;
      checks++; if (got != 268435440) begin errors++; $display("FAIL ovf_word0: got %0d expected 268435440", got); end
      got = (hs_data.size() > 1) ? int'(hs_data[1]) : -1;
      checks++; if (got != 268435450) begin errors++; $display("FAIL ovf_word1: got %0d expected 268435450", got); end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL ovf_done_count: got %0d expected 1", done_cnt - d0); end
      checks++; if (cur_inc !== PW'(268435450)) begin errors++; $display("FAIL ovf_cur_inc: got %0d expected 268435450", cur_inc); end
   endtask

   task automatic test_degenerate();
      int d0, got;
      clear_log();
      set_cfg(500, 600, 0, 0, 1'b1);
      tready = 1'b1;
      d0 = done_cnt;
      pulse_start();
      set_cfg(777, 900, 5, 3, 1'b1);
      pulse_start();
      for (int i = 0; i < 50 && done_cnt == d0; i++) tick();
      for (int i = 0; i < 10; i++) tick();
      checks++; if (hs_data.size() != 1) begin errors++; $display("FAIL degen_count: got %0d expected 1", hs_data.size()); end
      got = (hs_data.size() > 0) ? int'(hs_data[0]) : -1;
      checks++; if (got != 500) begin errors++; $display("FAIL degen_word: got %0d expected 500", got); end
      got = (hs_cyc.size() > 0 && done_cyc.size() > 0) ? done_cyc[0] - hs_cyc[0] : -1;
      checks++; if (got != 2) begin errors++; $display("FAIL degen_done_latency: got %0d expected 2", got); end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL degen_done_count: got %0d expected 1", done_cnt - d0); end
      clear_log();
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_abort_start_busy: got %0b expected 0", busy); end
      for (int i = 0; i < 10; i++) tick();
      checks++; if (hs_data.size() != 0) begin errors++; $display("FAIL idle_abort_start_words: got %0d expected 0", hs_data.size()); end
      clear_log();
      set_cfg(2000, 2000, 0, 20, 1'b0);
      d0 = done_cnt;
      pulse_start();
      for (int i = 0; i < 20 && hs_data.size() < 1; i++) tick();
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_abort_start_busy: got %0b expected 0", busy); end
      for (int i = 0; i < 30; i++) tick();
      checks++; if (hs_data.size() != 1) begin errors++; $display("FAIL busy_abort_start_words: got %0d expected 1", hs_data.size()); end
      checks++; if (done_cnt != d0) begin errors++; $display("FAIL busy_abort_no_done: got %0d expected %0d", done_cnt, d0); end
      checks++; if (cur_inc !== PW'(2000)) begin errors++; $display("FAIL busy_abort_cur_inc: got %0d expected 2000", cur_inc); end
   endtask

   task automatic test_reset_mid_send();
      int exp_v[5] = '{1000, 1100, 1200, 1300, 1400};
      int d0, got;
      clear_log();
      set_cfg(3000, 3200, 100, 3, 1'b0);
      tready = 1'b0;
      pulse_start();
      checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL rst_pre_tvalid: got %0b expected 1", tvalid); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL rst_async_tvalid: got %0b expected 0", tvalid); end
      checks++; if (cur_inc !== '0) begin errors++; $display("FAIL rst_async_cur_inc: got %0d expected 0", cur_inc); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %0b expected 0", busy); end
      tick();
      tick();
      rst_n = 1'b1;
      tready = 1'b1;
      tick();
      clear_log();
      set_cfg(1000, 1400, 100, 4, 1'b0);
      d0 = done_cnt;
      pulse_start();
      for (int i = 0; i < 200 && done_cnt == d0; i++) tick();
      checks++; if (hs_data.size() != 5) begin errors++; $display("FAIL rst_restart_count: got %0d expected 5", hs_data.size()); end
      for (int i = 0; i < 5; i++) begin
         got = (i < hs_data.size()) ? int'(hs_data[i]) : -1;
         checks++; if (got != exp_v[i]) begin errors++; $display("FAIL rst_restart_word%0d: got %0d expected %0d", i, got, exp_v[i]); end
      end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL rst_restart_done: got %0d expected 1", done_cnt - d0); end
   endtask

   initial begin
      test_reset();
      test_basic_sweep();
      test_stall();
      test_continuous();
      test_overflow();
      test_degenerate();
      test_reset_mid_send();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
